// File: rtl/snake_engine.sv
// Snake game engine: segment store, movement/eat/collision FSM and a segment read port.
// A step walks CALC -> SCAN (one compare per segment) -> COMMIT, then returns to READY.
module snake_engine #(
    parameter int unsigned GRID_W    = 160,
    parameter int unsigned GRID_H    = 120,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned MAX_LEN   = 64,
    parameter int unsigned BORDER    = 2,
    parameter int unsigned WRAP      = 0,
    parameter int unsigned START_X   = 30,
    parameter int unsigned START_Y   = 20,
    parameter int unsigned START_LEN = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         step,
    input  logic                         dir_valid,
    input  logic [1:0]                   dir_in,
    input  logic [X_W-1:0]               apple_x,
    input  logic [Y_W-1:0]               apple_y,
    input  logic [$clog2(MAX_LEN)-1:0]   seg_idx,
    output logic [X_W-1:0]               seg_x,
    output logic [Y_W-1:0]               seg_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic [1:0]                   direction,
    output logic                         busy,
    output logic                         alive,
    output logic                         ate,
    output logic                         died
);

    localparam int unsigned IW = $clog2(MAX_LEN);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] D_LEFT  = 2'b00;
    localparam logic [1:0] D_RIGHT = 2'b01;
    localparam logic [1:0] D_DOWN  = 2'b10;
    localparam logic [1:0] D_UP    = 2'b11;

    localparam logic [X_W-1:0] X_ONE = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);
    localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_LO  = X_W'(BORDER);
    localparam logic [Y_W-1:0] Y_LO  = Y_W'(BORDER);
    localparam logic [X_W-1:0] X_HI  = X_W'(GRID_W - BORDER);
    localparam logic [Y_W-1:0] Y_HI  = Y_W'(GRID_H - BORDER);
    localparam logic [LW-1:0]  L_MAX = LW'(MAX_LEN);
    localparam logic [LW-1:0]  L_ONE = LW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_READY, S_CALC, S_SCAN, S_COMMIT, S_DEAD
    } state_t;

    state_t state, state_nx;

    logic [X_W-1:0] seg_xs [MAX_LEN];
    logic [Y_W-1:0] seg_ys [MAX_LEN];
    logic [1:0]     pend_q;
    logic [1:0]     move_q;
    logic [X_W-1:0] nhx_q;
    logic [Y_W-1:0] nhy_q;
    logic           eat_q;
    logic [IW-1:0]  idx_q;

    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic           at_edge;
    logic           wall_c;
    logic           eat_c;
    logic           hit_c;
    logic           is_tail_c;
    logic           busy_nx, alive_nx, ate_nx, died_nx;

    // Candidate head one cell along the pending direction, with grid-edge detection.
    always_comb begin
        cx      = seg_xs[0];
        cy      = seg_ys[0];
        at_edge = 1'b0;
        case (pend_q)
            D_LEFT: begin
                if (seg_xs[0] == '0) begin
                    cx      = X_MAX;
                    at_edge = 1'b1;
                end else begin
                    cx = seg_xs[0] - X_ONE;
                end
            end
            D_RIGHT: begin
                if (seg_xs[0] == X_MAX) begin
                    cx      = '0;
                    at_edge = 1'b1;
                end else begin
                    cx = seg_xs[0] + X_ONE;
                end
            end
            D_DOWN: begin
                if (seg_ys[0] == Y_MAX) begin
                    cy      = '0;
                    at_edge = 1'b1;
                end else begin
                    cy = seg_ys[0] + Y_ONE;
                end
            end
            default: begin
                if (seg_ys[0] == '0) begin
                    cy      = Y_MAX;
                    at_edge = 1'b1;
                end else begin
                    cy = seg_ys[0] - Y_ONE;
                end
            end
        endcase
        wall_c = (WRAP == 0) &&
                 (at_edge || cx < X_LO || cx >= X_HI || cy < Y_LO || cy >= Y_HI);
        eat_c  = (cx == apple_x) && (cy == apple_y);
    end

    // The tail only counts as a collision when it is about to be kept (eating).
    assign hit_c     = (seg_xs[idx_q] == nhx_q) && (seg_ys[idx_q] == nhy_q);
    assign is_tail_c = ((LW'(idx_q) + L_ONE) == length);

    always_comb begin
        state_nx = state;
        busy_nx  = 1'b0;
        alive_nx = 1'b0;
        ate_nx   = 1'b0;
        died_nx  = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   state_nx = S_READY;
            S_READY:  if (step) state_nx = S_CALC;
            S_CALC:   state_nx = wall_c ? S_DEAD : S_SCAN;
            S_SCAN: begin
                if (hit_c && !(is_tail_c && !eat_q)) state_nx = S_DEAD;
                else if (is_tail_c)                   state_nx = S_COMMIT;
            end
            S_COMMIT: state_nx = S_READY;
            S_DEAD:   if (start) state_nx = S_LOAD;
            default:  state_nx = S_IDLE;
        endcase
        busy_nx  = (state_nx == S_CALC) || (state_nx == S_SCAN) || (state_nx == S_COMMIT);
        alive_nx = busy_nx || (state_nx == S_READY);
        ate_nx   = (state_nx == S_COMMIT) && eat_q;
        died_nx  = (state_nx == S_DEAD) && (state != S_DEAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            alive <= 1'b0;
            ate   <= 1'b0;
            died  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= busy_nx;
            alive <= alive_nx;
            ate   <= ate_nx;
            died  <= died_nx;
        end
    end

    // Segment store, direction tracking and per-step scratch registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_xs[i] <= '0;
                seg_ys[i] <= '0;
            end
            length    <= '0;
            direction <= D_RIGHT;
            pend_q    <= D_RIGHT;
            move_q    <= D_RIGHT;
            nhx_q     <= '0;
            nhy_q     <= '0;
            eat_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            if (alive && dir_valid && (dir_in != (direction ^ 2'b01)))
                pend_q <= dir_in;
            case (state)
                S_LOAD: begin
                    for (int unsigned i = 0; i < MAX_LEN; i++) begin
                        if (i < START_LEN) begin
                            seg_xs[i] <= X_W'(START_X - i);
                            seg_ys[i] <= Y_W'(START_Y);
                        end
                    end
                    length    <= LW'(START_LEN);
                    direction <= D_RIGHT;
                    pend_q    <= D_RIGHT;
                end
                S_CALC: begin
                    nhx_q  <= cx;
                    nhy_q  <= cy;
                    eat_q  <= eat_c;
                    move_q <= pend_q;
                    idx_q  <= '0;
                end
                S_SCAN: idx_q <= idx_q + IW'(1);
                S_COMMIT: begin
                    for (int unsigned i = 1; i < MAX_LEN; i++) begin
                        seg_xs[i] <= seg_xs[i-1];
                        seg_ys[i] <= seg_ys[i-1];
                    end
                    seg_xs[0] <= nhx_q;
                    seg_ys[0] <= nhy_q;
                    direction <= move_q;
                    if (eat_q && (length < L_MAX))
                        length <= length + L_ONE;
                end
                default: ;
            endcase
        end
    end

    assign seg_x = (LW'(seg_idx) < length) ? seg_xs[seg_idx] : '0;
    assign seg_y = (LW'(seg_idx) < length) ? seg_ys[seg_idx] : '0;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed vector table, hand sequences for
// walls/saturation/reset, and random games checked against a queue-based snake model.
module tb_snake_engine;

    logic       clk = 1'b0;
    logic       reset, start, step, dir_valid;
    logic [1:0] dir_in;
    logic [7:0] apple_x;
    logic [6:0] apple_y;
    logic [5:0] seg_idx;
    logic [7:0] seg_x;
    logic [6:0] seg_y;
    logic [6:0] length;
    logic [1:0] direction;
    logic       busy, alive, ate, died;

    logic       w_start, w_step;
    logic [7:0] w_seg_x;
    logic [6:0] w_seg_y;
    logic [6:0] w_length;
    logic [1:0] w_direction;
    logic       w_busy, w_alive, w_ate, w_died;

    snake_engine u_dut (
        .clk(clk), .reset(reset), .start(start), .step(step),
        .dir_valid(dir_valid), .dir_in(dir_in), .apple_x(apple_x), .apple_y(apple_y),
        .seg_idx(seg_idx), .seg_x(seg_x), .seg_y(seg_y), .length(length),
        .direction(direction), .busy(busy), .alive(alive), .ate(ate), .died(died)
    );

    snake_engine #(.WRAP(1), .START_X(158)) u_wrap (
        .clk(clk), .reset(reset), .start(w_start), .step(w_step),
        .dir_valid(dir_valid), .dir_in(dir_in), .apple_x(apple_x), .apple_y(apple_y),
        .seg_idx(seg_idx), .seg_x(w_seg_x), .seg_y(w_seg_y), .length(w_length),
        .direction(w_direction), .busy(w_busy), .alive(w_alive), .ate(w_ate), .died(w_died)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int restart; int dv; int d; int ax; int ay;
        int hx; int hy; int len; int alv; int nate;
    } vec_t;
    vec_t tbl[13];

    int mx[$];
    int my[$];
    int mdir, mpend;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_seg(input int i, output int x, output int y);
        seg_idx = 6'(i);
        @(negedge clk);
        x = int'(seg_x);
        y = int'(seg_y);
    endtask

    task automatic do_start();
        if (alive) begin
            reset = 1'b1;
            #2;
            reset = 1'b0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic do_dir(input int d);
        dir_valid = 1'b1;
        dir_in    = 2'(d);
        tick();
        dir_valid = 1'b0;
    endtask

    // Pulse step and follow the move to completion, counting busy cycles and pulses.
    task automatic do_step(output int bc, output int na, output int nd);
        step = 1'b1;
        tick();
        step = 1'b0;
        bc = 0; na = 0; nd = 0;
        for (int k = 0; k < 200; k++) begin
            na += int'(ate);
            nd += int'(died);
            if (!busy) break;
            bc++;
            tick();
        end
        if (busy) begin
            errors++;
            checks++;
            $display("FAIL step_timeout: busy still high after 200 cycles");
        end
    endtask

    function automatic void next_pos(input int hx, input int hy, input int d,
                                     output int nx, output int ny);
        nx = hx; ny = hy;
        case (d)
            0: nx = hx - 1;
            1: nx = hx + 1;
            2: ny = hy + 1;
            default: ny = hy - 1;
        endcase
    endfunction

    task automatic m_start();
        mx = {30, 29, 28};
        my = {20, 20, 20};
        mdir = 1; mpend = 1;
    endtask

    task automatic m_step(input int dv, input int d, input int ax, input int ay,
                          output bit dead, output bit eat);
        int nx, ny;
        if (dv != 0 && d != (mdir ^ 1)) mpend = d;
        next_pos(mx[0], my[0], mpend, nx, ny);
        dead = (nx < 2 || nx >= 158 || ny < 2 || ny >= 118);
        eat  = 1'b0;
        if (!dead) begin
            eat = (nx == ax && ny == ay);
            for (int i = 0; i < mx.size(); i++)
                if (mx[i] == nx && my[i] == ny && !(i == mx.size() - 1 && !eat)) dead = 1'b1;
        end
        if (dead) eat = 1'b0;
        else begin
            mx.push_front(nx);
            my.push_front(ny);
            if (!eat || mx.size() > 64) begin
                void'(mx.pop_back());
                void'(my.pop_back());
            end
            mdir = mpend;
        end
    endtask

    initial begin
        int bc, na, nd, x, y, prev_len, blen, dv, d, ax, ay, pd, px, py, tot_ate;
        bit mdead, meat;

        tbl[0]  = '{1, 0, 0, 0,  0,  31, 20, 3, 1, 0};
        tbl[1]  = '{1, 1, 0, 0,  0,  31, 20, 3, 1, 0};
        tbl[2]  = '{0, 1, 3, 0,  0,  31, 19, 3, 1, 0};
        tbl[3]  = '{1, 0, 0, 31, 20, 31, 20, 4, 1, 1};
        tbl[4]  = '{0, 0, 0, 32, 20, 32, 20, 5, 1, 1};
        tbl[5]  = '{0, 1, 2, 0,  0,  32, 21, 5, 1, 0};
        tbl[6]  = '{0, 1, 0, 0,  0,  31, 21, 5, 1, 0};
        tbl[7]  = '{0, 1, 3, 0,  0,  31, 21, 5, 0, 0};
        tbl[8]  = '{1, 0, 0, 31, 20, 31, 20, 4, 1, 1};
        tbl[9]  = '{0, 1, 2, 0,  0,  31, 21, 4, 1, 0};
        tbl[10] = '{0, 1, 0, 0,  0,  30, 21, 4, 1, 0};
        tbl[11] = '{0, 1, 3, 0,  0,  30, 20, 4, 1, 0};
        tbl[12] = '{0, 1, 1, 0,  0,  31, 20, 4, 1, 0};

        reset = 1'b1; start = 1'b0; step = 1'b0; dir_valid = 1'b0; dir_in = 2'b00;
        apple_x = '0; apple_y = '0; seg_idx = '0; w_start = 1'b0; w_step = 1'b0;
        prev_len = 3;
        tick(); tick();
        chk("rst_length", int'(length), 0);
        chk("rst_direction", int'(direction), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_alive", int'(alive), 0);
        chk("rst_ate", int'(ate), 0);
        chk("rst_died", int'(died), 0);
        read_seg(0, x, y);
        chk("rst_seg0_x", x, 0);
        reset = 1'b0;
        tick();
        step = 1'b1; tick(); step = 1'b0; tick();
        chk("idle_ignores_step", int'(busy), 0);

        // Directed vector table
        for (int r = 0; r < 13; r++) begin
            if (tbl[r].restart != 0) begin
                do_start();
                prev_len = 3;
            end
            apple_x = 8'(tbl[r].ax);
            apple_y = 7'(tbl[r].ay);
            if (tbl[r].dv != 0) do_dir(tbl[r].d);
            do_step(bc, na, nd);
            read_seg(0, x, y);
            chk($sformatf("vec%0d_head_x", r), x, tbl[r].hx);
            chk($sformatf("vec%0d_head_y", r), y, tbl[r].hy);
            chk($sformatf("vec%0d_length", r), int'(length), tbl[r].len);
            chk($sformatf("vec%0d_alive", r), int'(alive), tbl[r].alv);
            chk($sformatf("vec%0d_ate", r), na, tbl[r].nate);
            chk($sformatf("vec%0d_died", r), nd, 1 - tbl[r].alv);
            if (tbl[r].alv != 0) chk($sformatf("vec%0d_busy_cycles", r), bc, prev_len + 2);
            prev_len = tbl[r].len;
        end

        // Plain step: full body and beyond-length read
        do_start();
        apple_x = '0; apple_y = '0;
        do_step(bc, na, nd);
        chk("plain_busy", bc, 5);
        for (int i = 0; i < 3; i++) begin
            read_seg(i, x, y);
            chk($sformatf("plain_seg%0d_x", i), x, 31 - i);
            chk($sformatf("plain_seg%0d_y", i), y, 20);
        end
        read_seg(3, x, y);
        chk("plain_seg3_zero", x, 0);

        // Eat from load: old tail retained
        do_start();
        apple_x = 8'd31; apple_y = 7'd20;
        do_step(bc, na, nd);
        for (int i = 0; i < 4; i++) begin
            read_seg(i, x, y);
            chk($sformatf("eat_seg%0d_x", i), x, 31 - i);
            chk($sformatf("eat_seg%0d_y", i), y, 20);
        end

        // Right wall
        do_start();
        apple_x = '0; apple_y = '0;
        tot_ate = 0;
        for (int k = 0; k < 127; k++) begin
            do_step(bc, na, nd);
            tot_ate += nd;
        end
        read_seg(0, x, y);
        chk("wall_head_x", x, 157);
        chk("wall_no_death_yet", tot_ate, 0);
        do_step(bc, na, nd);
        chk("wall_died", nd, 1);
        chk("wall_alive", int'(alive), 0);
        read_seg(0, x, y);
        chk("wall_head_frozen_x", x, 157);
        chk("wall_length", int'(length), 3);
        do_dir(2);
        do_step(bc, na, nd);
        read_seg(0, x, y);
        chk("dead_ignores_step", x, 157);
        chk("dead_direction", int'(direction), 1);

        // Length saturation
        do_start();
        tot_ate = 0;
        for (int k = 0; k < 62; k++) begin
            apple_x = 8'(31 + k); apple_y = 7'd20;
            do_step(bc, na, nd);
            tot_ate += na;
            if (k == 60) chk("sat_len_reach", int'(length), 64);
        end
        chk("sat_length", int'(length), 64);
        chk("sat_ate_count", tot_ate, 62);
        chk("sat_alive", int'(alive), 1);
        read_seg(0, x, y);
        chk("sat_head_x", x, 92);
        read_seg(63, x, y);
        chk("sat_tail_x", x, 29);

        // Reset in the third SCAN cycle
        do_start();
        apple_x = '0; apple_y = '0; seg_idx = '0;
        step = 1'b1; tick(); step = 1'b0;
        tick(); tick(); tick();
        chk("scan_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("scan_rst_busy", int'(busy), 0);
        chk("scan_rst_alive", int'(alive), 0);
        chk("scan_rst_length", int'(length), 0);
        chk("scan_rst_seg_x", int'(seg_x), 0);
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        chk("start_during_reset", int'(length), 0);
        reset = 1'b0;
        tick();
        chk("after_reset_idle", int'(alive), 0);
        do_start();
        chk("restore_length", int'(length), 3);
        chk("restore_alive", int'(alive), 1);
        chk("restore_direction", int'(direction), 1);
        read_seg(0, x, y);
        chk("restore_head_x", x, 30);
        chk("restore_head_y", y, 20);

        // Random games against the model
        for (int g = 0; g < 6; g++) begin
            do_start();
            m_start();
            for (int s = 0; s < 40; s++) begin
                dv = int'($urandom_range(0, 1));
                d  = int'($urandom_range(0, 3));
                pd = (dv != 0 && d != (mdir ^ 1)) ? d : mpend;
                next_pos(mx[0], my[0], pd, px, py);
                if ($urandom_range(0, 2) == 0) begin
                    ax = px; ay = py;
                end else begin
                    ax = int'($urandom_range(0, 159));
                    ay = int'($urandom_range(0, 119));
                end
                apple_x = 8'(ax); apple_y = 7'(ay);
                if (dv != 0) do_dir(d);
                blen = mx.size();
                m_step(dv, d, ax, ay, mdead, meat);
                do_step(bc, na, nd);
                read_seg(0, x, y);
                chk($sformatf("rnd%0d_%0d_head_x", g, s), x, mx[0]);
                chk($sformatf("rnd%0d_%0d_head_y", g, s), y, my[0]);
                chk($sformatf("rnd%0d_%0d_length", g, s), int'(length), mx.size());
                chk($sformatf("rnd%0d_%0d_alive", g, s), int'(alive), mdead ? 0 : 1);
                chk($sformatf("rnd%0d_%0d_ate", g, s), na, meat ? 1 : 0);
                chk($sformatf("rnd%0d_%0d_died", g, s), nd, mdead ? 1 : 0);
                if (!mdead) chk($sformatf("rnd%0d_%0d_busy", g, s), bc, blen + 2);
                if (mdead) break;
            end
            for (int i = 0; i < mx.size(); i++) begin
                read_seg(i, x, y);
                chk($sformatf("rnd%0d_seg%0d_x", g, i), x, mx[i]);
                chk($sformatf("rnd%0d_seg%0d_y", g, i), y, my[i]);
            end
        end

        // Wrapping instance crosses the right edge
        apple_x = '0; apple_y = '0; dir_valid = 1'b0; seg_idx = '0;
        w_start = 1'b1; tick(); w_start = 1'b0; tick();
        chk("wrap_alive", int'(w_alive), 1);
        for (int k = 0; k < 2; k++) begin
            w_step = 1'b1; tick(); w_step = 1'b0;
            for (int c = 0; c < 50 && w_busy; c++) tick();
            chk($sformatf("wrap_step%0d_busy", k), int'(w_busy), 0);
        end
        @(negedge clk);
        chk("wrap_head_x", int'(w_seg_x), 0);
        chk("wrap_head_y", int'(w_seg_y), 20);
        chk("wrap_still_alive", int'(w_alive), 1);
        chk("wrap_length", int'(w_length), 3);
        chk("wrap_direction", int'(w_direction), 1);
        chk("wrap_no_pulse", int'(w_died) + int'(w_ate), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
